// File: rtl/conv_pe_sequencer.sv
// Sequencer for one DSP-cascade convolution PE: serial weight load, raster
// feature-map streaming, continuous-enable drain and in-order result write-back.
module conv_pe_sequencer #(
    parameter  int KERNEL_SIZE = 3,
    parameter  int FM_SIZE     = 4,
    parameter  int DRAIN_MAX   = 4 * FM_SIZE * KERNEL_SIZE,
    localparam int N_PIX       = FM_SIZE * FM_SIZE,
    localparam int N_OUT       = (FM_SIZE - KERNEL_SIZE + 1) * (FM_SIZE - KERNEL_SIZE + 1),
    localparam int FM_AW       = $clog2(N_PIX),
    localparam int RES_AW      = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int N_W         = KERNEL_SIZE * KERNEL_SIZE
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    input  logic                  i_w_valid,
    input  logic [17:0]           i_w_data,
    output logic                  o_w_ready,
    output logic [N_W*18-1:0]     o_weight,
    output logic                  o_fm_rd,
    output logic [FM_AW-1:0]      o_fm_addr,
    input  logic [29:0]           i_fm_data,
    output logic [29:0]           o_pe_data,
    output logic                  o_pe_en,
    input  logic                  i_pe_valid,
    input  logic [47:0]           i_pe_p,
    output logic                  o_res_we,
    output logic [RES_AW-1:0]     o_res_addr,
    output logic [47:0]           o_res_data
);

    localparam int WI_W = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int RC_W = $clog2(N_OUT + 1);
    localparam int DC_W = $clog2(DRAIN_MAX + 1);

    localparam logic [WI_W-1:0]  W_LAST   = WI_W'(N_W - 1);
    localparam logic [FM_AW-1:0] PIX_LAST = FM_AW'(N_PIX - 1);
    localparam logic [RC_W-1:0]  RC_FULL  = RC_W'(N_OUT);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DRAIN_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                w_ready_q;
    logic [17:0]         weight_q [N_W];
    logic [WI_W-1:0]     w_idx_q;
    logic                fm_rd_q;
    logic [FM_AW-1:0]    fm_addr_q;
    logic                rd_dly_q;
    logic                res_we_q;
    logic [RES_AW-1:0]   res_addr_q;
    logic [47:0]         res_data_q;
    logic [RC_W-1:0]     res_cnt_q;
    logic [DC_W-1:0]     drain_cnt_q;

    logic w_acc;
    logic res_take;

    assign w_acc    = w_ready_q & i_w_valid;
    // Results are only taken while the PE is actually being fed or drained.
    assign res_take = ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                      i_pe_valid && (res_cnt_q < RC_FULL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            w_ready_q   <= 1'b0;
            weight_q    <= '{default: '0};
            w_idx_q     <= '0;
            fm_rd_q     <= 1'b0;
            fm_addr_q   <= '0;
            rd_dly_q    <= 1'b0;
            res_we_q    <= 1'b0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
            res_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            done_q   <= 1'b0;
            res_we_q <= 1'b0;
            rd_dly_q <= fm_rd_q;

            if (w_acc) begin
                weight_q[w_idx_q] <= i_w_data;
            end

            if (res_take) begin
                res_we_q   <= 1'b1;
                res_addr_q <= res_cnt_q[RES_AW-1:0];
                res_data_q <= i_pe_p;
                res_cnt_q  <= res_cnt_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        state_q     <= S_LOAD_W;
                        busy_q      <= 1'b1;
                        w_ready_q   <= 1'b1;
                        err_q       <= 1'b0;
                        w_idx_q     <= '0;
                        fm_addr_q   <= '0;
                        res_cnt_q   <= '0;
                        drain_cnt_q <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (w_acc) begin
                        if (w_idx_q == W_LAST) begin
                            state_q   <= S_STREAM;
                            w_ready_q <= 1'b0;
                            w_idx_q   <= '0;
                            fm_rd_q   <= 1'b1;
                            fm_addr_q <= '0;
                        end else begin
                            w_idx_q <= w_idx_q + 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (fm_addr_q == PIX_LAST) begin
                        state_q   <= S_DRAIN;
                        fm_rd_q   <= 1'b0;
                        fm_addr_q <= '0;
                    end else begin
                        fm_addr_q <= fm_addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Uses the registered count so DONE follows the final write.
                    if (res_cnt_q == RC_FULL) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (drain_cnt_q == DC_LAST) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    res_cnt_q   <= '0;
                    drain_cnt_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Abort overrides everything above; weights and the error flag survive.
            if (i_abort && (state_q != S_IDLE)) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
                w_ready_q   <= 1'b0;
                w_idx_q     <= '0;
                fm_rd_q     <= 1'b0;
                fm_addr_q   <= '0;
                rd_dly_q    <= 1'b0;
                res_we_q    <= 1'b0;
                res_cnt_q   <= '0;
                drain_cnt_q <= '0;
            end
        end
    end

    for (genvar gi = 0; gi < N_W; gi++) begin : g_weight
        assign o_weight[gi*18 +: 18] = weight_q[gi];
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_w_ready  = w_ready_q;
    assign o_fm_rd    = fm_rd_q;
    assign o_fm_addr  = fm_addr_q;
    assign o_pe_en    = rd_dly_q | (state_q == S_DRAIN);
    assign o_pe_data  = rd_dly_q ? i_fm_data : '0;
    assign o_res_we   = res_we_q;
    assign o_res_addr = res_addr_q;
    assign o_res_data = res_data_q;

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Bench for conv_pe_sequencer: buffer and PE models around the DUT, a result
// scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_conv_pe_sequencer;

    localparam int K         = 3;
    localparam int F         = 4;
    localparam int DRAIN_MAX = 4 * F * K;
    localparam int N_PIX     = F * F;
    localparam int N_W       = K * K;
    localparam int FM_AW     = $clog2(N_PIX);
    localparam int RES_AW    = 2;

    logic               clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_start = 1'b0;
    logic               i_abort = 1'b0;
    logic               o_busy, o_done, o_err;
    logic               i_w_valid = 1'b0;
    logic [17:0]        i_w_data = '0;
    logic               o_w_ready;
    logic [N_W*18-1:0]  o_weight;
    logic               o_fm_rd;
    logic [FM_AW-1:0]   o_fm_addr;
    logic [29:0]        i_fm_data = '0;
    logic [29:0]        o_pe_data;
    logic               o_pe_en;
    logic               i_pe_valid;
    logic [47:0]        i_pe_p = '0;
    logic               o_res_we;
    logic [RES_AW-1:0]  o_res_addr;
    logic [47:0]        o_res_data;

    logic pe_v_q  = 1'b0;
    logic force_v = 1'b0;
    logic pe_mute = 1'b0;
    assign i_pe_valid = pe_v_q | force_v;

    conv_pe_sequencer #(
        .KERNEL_SIZE (K),
        .FM_SIZE     (F),
        .DRAIN_MAX   (DRAIN_MAX)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .i_w_valid  (i_w_valid),
        .i_w_data   (i_w_data),
        .o_w_ready  (o_w_ready),
        .o_weight   (o_weight),
        .o_fm_rd    (o_fm_rd),
        .o_fm_addr  (o_fm_addr),
        .i_fm_data  (i_fm_data),
        .o_pe_data  (o_pe_data),
        .o_pe_en    (o_pe_en),
        .i_pe_valid (i_pe_valid),
        .i_pe_p     (i_pe_p),
        .o_res_we   (o_res_we),
        .o_res_addr (o_res_addr),
        .o_res_data (o_res_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_exp = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, acc_cnt = 0;
    int last_we_cyc = 0, last_rd_cyc = 0, done_cyc = 0;

    typedef struct {
        int     addr;
        longint data;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Feature-map buffer: pixel at address n is n, one-cycle read latency.
    always @(posedge clk) begin
        if (o_fm_rd) i_fm_data <= 30'(o_fm_addr);
    end

    // PE model: counts enabled pixels, emits each complete window one cycle later.
    longint pix [N_PIX];
    int     pe_idx = 0;
    always @(posedge clk) begin
        longint acc;
        int r, c;
        pe_v_q <= 1'b0;
        i_pe_p <= '0;
        if (!o_pe_en) begin
            pe_idx = 0;
        end else begin
            if (pe_idx < N_PIX) begin
                pix[pe_idx] = longint'($signed(o_pe_data));
                r = pe_idx / F;
                c = pe_idx % F;
                if (r >= K - 1 && c >= K - 1) begin
                    acc = 0;
                    for (int kr = 0; kr < K; kr++)
                        for (int kc = 0; kc < K; kc++)
                            acc += longint'($signed(o_weight[(kr*K+kc)*18 +: 18])) *
                                   pix[(r-K+1+kr)*F + (c-K+1+kc)];
                    if (!pe_mute) begin
                        pe_v_q <= 1'b1;
                        i_pe_p <= acc[47:0];
                    end
                end
            end
            pe_idx++;
        end
    end

    // Monitor: read-address sequence, scoreboard pops, event bookkeeping.
    always @(negedge clk) begin
        exp_t e;
        if (o_w_ready && i_w_valid) acc_cnt++;
        if (o_fm_rd) begin
            checks++;
            if (int'(o_fm_addr) != rd_exp) begin
                errors++;
                $display("FAIL rd_addr: got %0d, expected %0d", o_fm_addr, rd_exp);
            end
            rd_exp++;
            rd_cnt++;
            last_rd_cyc = cyc;
        end
        if (o_res_we) begin
            wr_cnt++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_extra: write addr %0d data %0d, expected no write", o_res_addr, o_res_data);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (int'(o_res_addr) != e.addr) begin
                    errors++;
                    $display("FAIL res_addr: got %0d, expected %0d", o_res_addr, e.addr);
                end
                checks++;
                if (o_res_data !== 48'(e.data)) begin
                    errors++;
                    $display("FAIL res_data@%0d: got %0d, expected %0d", e.addr, o_res_data, e.data);
                end
            end
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        rd_exp = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0; acc_cnt = 0;
    endtask

    task automatic push4(input longint d0, input longint d1, input longint d2, input longint d3);
        exp_q.push_back('{0, d0});
        exp_q.push_back('{1, d1});
        exp_q.push_back('{2, d2});
        exp_q.push_back('{3, d3});
    endtask

    task automatic start_run(output int c0);
        c0 = cyc;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("busy_cycle1", longint'(o_busy), 1);
        check("wready_cycle1", longint'(o_w_ready), 1);
    endtask

    task automatic load_weights(input bit toggle, input bit ramp, input int c0);
        int n;
        for (int k = 0; k < N_W; k++) begin
            i_w_valid = 1'b1;
            i_w_data  = ramp ? 18'(k + 1) : 18'd1;
            n = 0;
            while (o_w_ready !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            if (n == 20) check("wready_wait", longint'(o_w_ready), 1);
            tick();
            if (toggle && k != N_W - 1) begin
                i_w_valid = 1'b0;
                tick();
            end
        end
        i_w_valid = 1'b0;
        check("first_rd_after_last_w", longint'(o_fm_rd), 1);
        check("first_rd_addr", longint'(o_fm_addr), 0);
        if (!toggle) check("first_rd_cycle", longint'(cyc - c0), N_W + 1);
    endtask

    task automatic wait_addr(input int a);
        int n = 0;
        while (!(o_fm_rd === 1'b1 && int'(o_fm_addr) == a) && n < 60) begin
            tick();
            n++;
        end
        check("reach_rd_addr", longint'(o_fm_addr), a);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (o_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", longint'(o_done), 1);
        check("busy_at_done", longint'(o_busy), 1);
        check("pe_en_at_done", longint'(o_pe_en), 0);
        tick();
        check("busy_after_done", longint'(o_busy), 0);
        check("done_one_cycle", longint'(o_done), 0);
    endtask

    task automatic run_nominal();
        int c0;
        clear_stats();
        push4(45, 54, 81, 90);
        start_run(c0);
        load_weights(1'b0, 1'b0, c0);
        wait_done(200);
        check("done_after_last_we", longint'(done_cyc - last_we_cyc), 1);
        check("nom_reads", rd_cnt, 16);
        check("nom_writes", wr_cnt, 4);
        check("nom_done_count", done_cnt, 1);
        check("nom_err", longint'(o_err), 0);
        check("nom_accepted", acc_cnt, N_W);
        check("nom_sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int c0;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", longint'(o_busy), 0);
        check("rst_weight_zero", longint'(o_weight == '0), 1);
        check("rst_strobes", longint'({o_done, o_err, o_w_ready, o_fm_rd, o_pe_en, o_res_we}), 0);
        @(negedge clk);
        i_rst_n = 1'b1;
        tick();
        check("post_rst_busy", longint'(o_busy), 0);

        // Nominal run: all-ones weights, pixel n = n.
        run_nominal();

        // Weight backpressure with ramp weights 1..9.
        clear_stats();
        push4(303, 348, 483, 528);
        start_run(c0);
        load_weights(1'b1, 1'b1, c0);
        wait_done(200);
        check("bp_accepted", acc_cnt, N_W);
        check("bp_writes", wr_cnt, 4);
        for (int k = 0; k < N_W; k++)
            check($sformatf("w_slot%0d", k), longint'(o_weight[k*18 +: 18]), k + 1);
        check("bp_sb_empty", exp_q.size(), 0);

        // Abort in the middle of streaming.
        clear_stats();
        start_run(c0);
        load_weights(1'b0, 1'b0, c0);
        wait_addr(7);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_busy", longint'(o_busy), 0);
        check("abort_pe_en", longint'(o_pe_en), 0);
        check("abort_fm_rd", longint'(o_fm_rd), 0);
        repeat (5) tick();
        check("abort_no_done", done_cnt, 0);
        check("abort_no_writes", wr_cnt, 0);
        check("abort_reads", rd_cnt, 8);
        run_nominal();

        // Drain timeout: PE never reports a result.
        pe_mute = 1'b1;
        clear_stats();
        start_run(c0);
        load_weights(1'b0, 1'b0, c0);
        wait_done(300);
        pe_mute = 1'b0;
        check("to_err", longint'(o_err), 1);
        check("to_writes", wr_cnt, 0);
        check("to_done_count", done_cnt, 1);
        check("to_drain_len", longint'(done_cyc - last_rd_cyc), DRAIN_MAX + 1);
        tick();
        check("to_err_sticky", longint'(o_err), 1);

        // Spurious start in STREAM and held PE valid in DRAIN; start clears o_err.
        clear_stats();
        push4(45, 54, 81, 90);
        start_run(c0);
        check("err_cleared_by_start", longint'(o_err), 0);
        load_weights(1'b0, 1'b0, c0);
        wait_addr(3);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_addr(15);
        tick();
        force_v = 1'b1;
        repeat (10) tick();
        force_v = 1'b0;
        repeat (3) tick();
        check("sp_done_count", done_cnt, 1);
        check("sp_writes", wr_cnt, 4);
        check("sp_reads", rd_cnt, 16);
        check("sp_busy", longint'(o_busy), 0);
        check("sp_sb_empty", exp_q.size(), 0);

        // Asynchronous reset mid-stream.
        clear_stats();
        start_run(c0);
        load_weights(1'b0, 1'b0, c0);
        wait_addr(5);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_ctrl", longint'({o_busy, o_done, o_err, o_w_ready, o_fm_rd, o_pe_en, o_res_we}), 0);
        check("arst_addrs", longint'({o_fm_addr, o_res_addr}), 0);
        check("arst_data", longint'((o_pe_data == '0) && (o_res_data == '0)), 1);
        check("arst_weight_zero", longint'(o_weight == '0), 1);
        @(negedge clk);
        i_rst_n = 1'b1;
        tick();
        check("arst_busy_after", longint'(o_busy), 0);
        check("arst_weight_after", longint'(o_weight == '0), 1);
        repeat (3) tick();
        check("arst_no_done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_pe_sequencer.md
# conv_pe_sequencer

Sequencer for the DSP-cascade convolution PE. It loads the K×K weight vector serially into a held register, then streams one FM_SIZE×FM_SIZE feature map from a synchronous-read buffer into the PE in raster order. It keeps the PE enable continuously high through a drain phase and writes each valid PE result into a result buffer at consecutive addresses. It sits between the layer-level controller (start/done) and one PE instance.

## Interface
- KERNEL_SIZE, 3, kernel side K; must match the PE.
- FM_SIZE, 4, feature-map side F; F ≥ K.
- DRAIN_MAX, 4*FM_SIZE*KERNEL_SIZE, maximum drain cycles before timeout.
- Derived, not overridable:
  - N_PIX = F*F
  - N_OUT = (F-K+1)^2
  - FM_AW = $clog2(N_PIX)
  - RES_AW = max(1, $clog2(N_OUT))

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  run request; sampled only in IDLE.
- i_abort  in  1  abandon current run.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky drain timeout; cleared by an accepted start.
- i_w_valid  in  1  weight word valid.
- i_w_data  in  18  signed weight word.
- o_w_ready  out  1  weight word accepted when valid & ready.
- o_weight  out  K*K*18  weight vector to PE.
- o_fm_rd  out  1  feature-map buffer read strobe.
- o_fm_addr  out  FM_AW  read address; data returns next cycle.
- i_fm_data  in  30  signed pixel, valid one cycle after o_fm_rd.
- o_pe_data  out  30  pixel to the PE A input.
- o_pe_en  out  1  PE enable.
- i_pe_valid  in  1  PE output-valid.
- i_pe_p  in  48  PE result.
- o_res_we  out  1  result buffer write enable.
- o_res_addr  out  RES_AW  result address.
- o_res_data  out  48  result data.

## Operation
- States:
  - IDLE: i_start → LOAD_W.
  - LOAD_W: after the K*K-th accepted word → STREAM.
  - STREAM: after read of address N_PIX-1 → DRAIN.
  - DRAIN: result count = N_OUT, or DRAIN_MAX drain cycles elapsed → DONE.
  - DONE: → IDLE unconditionally.
- Reset: state IDLE. All outputs 0, including o_weight, addresses and counters.
- LOAD_W:
  - o_w_ready=1.
  - The k-th accepted word (k=0..K*K-1) is written to o_weight[18k+17:18k].
  - o_weight is unchanged outside LOAD_W and is retained across abort and done.
- STREAM:
  - o_fm_rd=1 every cycle.
  - o_fm_addr runs 0,1,…,N_PIX-1, one per cycle, no gaps.
- o_pe_en:
  - Is o_fm_rd delayed one cycle, OR state==DRAIN.
  - It therefore rises with the first returned pixel and stays high without a gap through DRAIN. The PE resets its internal output counter whenever enable drops.
  - It drops in the DONE cycle.
- o_pe_data = i_fm_data while the delayed read strobe is high, else 0. Zeros are fed during drain.
- Results:
  - While busy in STREAM or DRAIN, with i_pe_valid=1 and result count < N_OUT, one registered write issues next cycle: o_res_we=1, o_res_addr=count, o_res_data=i_pe_p. Count then increments.
  - i_pe_valid is ignored in IDLE, LOAD_W and DONE, and once count = N_OUT.
- Timeout: the drain counter reaching DRAIN_MAX sets o_err. DONE is still entered and o_done pulses.
- i_abort, any non-IDLE state:
  - Next state is IDLE; no o_done.
  - o_pe_en, o_fm_rd, o_w_ready and o_res_we go to 0 next cycle.
  - Counters clear; o_err is untouched.
  - i_abort has priority over every other transition, including a simultaneous i_start.
- i_start while busy is ignored.

## Timing
- Cycle 0: i_start sampled in IDLE.
- Cycle 1: o_busy=1 and o_w_ready=1.
- With i_w_valid held high, the last weight is accepted in cycle K*K. STREAM begins in cycle K*K+1.
- First o_pe_en is one cycle after the first o_fm_rd.
- A result write lags its i_pe_valid by exactly 1 cycle.
- o_done is high the cycle after the state leaves DRAIN, i.e. the cycle after the final o_res_we. o_busy falls in the cycle after o_done.
- The minimum gap from o_done to the next accepted i_start is 1 cycle (IDLE).
- Asynchronous reset mid-run: all outputs 0 immediately, no o_done. The reset release edge is synchronous to i_clk.

## Test plan
- Reset: assert i_rst_n=0 mid-STREAM → all outputs 0 asynchronously; after release, o_busy=0 and o_weight=0.
- Nominal, K=3, F=4, all weights 1, pixel at address n = n → exactly 16 reads at addresses 0..15 and exactly 4 writes. Addresses 0..3 receive 45, 54, 81, 90. o_done pulses once; o_err=0.
- Weight backpressure: i_w_valid toggles 1,0,1,… with words 1..9 → exactly 9 accepted, o_weight slot k = k+1, and the first o_fm_rd is one cycle after the 9th acceptance.
- Abort at o_fm_addr=7 → next cycle o_busy=0, o_pe_en=0, no o_done. A following full run reproduces the nominal results.
- Timeout: PE model never asserts i_pe_valid → after DRAIN_MAX=48 drain cycles, o_err=1, o_done pulses, and zero writes occur. The next i_start clears o_err.
- Spurious inputs: i_start pulsed during STREAM, and i_pe_valid held high for 10 cycles in DRAIN → no restart, exactly N_OUT=4 writes, and o_res_addr never exceeds 3.
